mem_wait_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction bus. It accepts one request at a time from the CPU-side initiator (address, read/write, access size, write data) and answers after a parameterised number of wait states with a single-cycle acknowledge. Byte and halfword stores are merged into the stored word, and misaligned or out-of-range accesses are flagged. It replaces the zero-wait memory when bus-latency tolerance in the control unit is exercised.

---
 rtl/mem_resp_pkg.sv | 44 ++++
 rtl/mem_resp_ram.sv | 41 ++++
 rtl/mem_wait_responder.sv | 141 ++++++++++++++
 tb/tb_mem_wait_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the wait-state memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } wr_lanes_t;

  // Builds the byte-enable mask and lane-replicated store data for a store.
  // Replicating the narrow operand across every lane lets the byte enables
  // alone pick the addressed lane, so no barrel shift is needed.
  function automatic wr_lanes_t lanes(input logic [1:0]  size,
                                      input logic [1:0]  lo,
                                      input logic [31:0] wdata);
    wr_lanes_t r;
    r.be   = 4'b0000;
    r.data = wdata;
    case (size)
      SZ_WORD: r.be = 4'b1111;
      SZ_HALF: begin
        r.be   = lo[1] ? 4'b1100 : 4'b0011;
        r.data = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        r.be   = 4'b0001 << lo;
        r.data = {4{wdata[7:0]}};
      end
      default: r.be = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Word-wide storage array with byte-enable writes and a registered read port.
module mem_resp_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [3:0]    be,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-wise write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register: loads on a read, clears on a rejected access, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-side bus responder: one request at a time, acknowledged after a
// fixed number of wait states, with lane merging and access checking.
module mem_wait_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        latch_en;

  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;

  logic [31:0] cur_addr;
  logic        cur_we;
  logic [1:0]  cur_size;
  logic [31:0] cur_wdata;
  logic        enter_ack;
  logic        bad;
  wr_lanes_t   wl;

  logic        err_q;

  // Next-state and counter logic; ACK entry is where the access takes effect.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          cnt_d    = 4'(LATENCY - 1);
          state_d  = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Selects the request being serviced: with single-cycle latency the ACK
  // entry coincides with acceptance, so the live inputs are used there.
  always_comb begin
    cur_addr  = addr_q;
    cur_we    = we_q;
    cur_size  = size_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_addr  = addr;
      cur_we    = we;
      cur_size  = size;
      cur_wdata = wdata;
    end
    enter_ack = (state_d == ACK) && (state_q != ACK);
    bad = (cur_size == SZ_ILL) ||
          ((cur_size == SZ_HALF) && cur_addr[0]) ||
          ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00)) ||
          ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    wl = lanes(cur_size, cur_addr[1:0], cur_wdata);
  end

  // State and wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch so the initiator's bus may change during the wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      wdata_q <= '0;
    end else if (latch_en) begin
      addr_q  <= addr;
      we_q    <= we;
      size_q  <= size;
      wdata_q <= wdata;
    end
  end

  // Error flag is only ever set for the ACK cycle of a rejected access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= enter_ack && bad;
    end
  end

  mem_resp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .wr_en (enter_ack && !bad && cur_we),
    .be    (wl.be),
    .rd_en (enter_ack && !bad && !cur_we),
    .rd_clr(enter_ack && bad),
    .index (cur_addr[AW+1:2]),
    .wdata (wl.data),
    .rdata (rdata)
  );

  assign ack  = (state_q == ACK);
  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for the wait-state responder at latencies 2, 1 and 15.
module tb_mem_wait_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        req_a, req_b, req_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        ack_a, ack_b, ack_c;
  logic        err_a, err_b, err_c;
  logic        busy_a, busy_b, busy_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata_a), .ack(ack_a), .err(err_a), .busy(busy_a)
  );

  mem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata_b), .ack(ack_b), .err(err_b), .busy(busy_b)
  );

  mem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_dut_c (
    .clk(clk), .reset(reset), .req(req_c), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata_c), .ack(ack_c), .err(err_c), .busy(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus transaction on the chosen instance (2, 1 or 15); returns the
  // number of edges from request to ack, and the ack-cycle rdata/err.
  task automatic run(input int which, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic e);
    logic got;
    we = w; size = sz; addr = a; wdata = d;
    case (which)
      1:       req_b = 1'b1;
      15:      req_c = 1'b1;
      default: req_a = 1'b1;
    endcase
    lat = 0;
    got = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      got = (which == 1) ? ack_b : (which == 15) ? ack_c : ack_a;
    end while (!got && lat < 40);
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    rd = (which == 1) ? rdata_b : (which == 15) ? rdata_c : rdata_a;
    e  = (which == 1) ? err_b   : (which == 15) ? err_c   : err_a;
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    int          n;
    int          acks;
    int          first_ack;
    int          last_ack;
    logic [31:0] rd;
    logic        e;

    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack",   ack_a,   0);
    check("reset_err",   err_a,   0);
    check("reset_busy",  busy_a,  0);
    check("reset_rdata", rdata_a, 0);
    reset = 1'b0;

    // Word path
    run(2, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, lat, rd, e);
    check("wr10_lat", lat, 2);
    check("wr10_err", e, 0);
    run(2, 1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
    check("rd10_lat", lat, 2);
    check("rd10_data", rd, 32'hDEADBEEF);
    check("rd10_err", e, 0);
    check("ack_one_cycle", ack_a, 0);
    check("busy_after_ack", busy_a, 0);

    // Lane merging
    run(2, 1'b1, 2'b00, 32'h20, 32'h11223344, lat, rd, e);
    run(2, 1'b1, 2'b10, 32'h22, 32'h000000AA, lat, rd, e);
    run(2, 1'b0, 2'b00, 32'h20, 32'h0, lat, rd, e);
    check("byte_merge", rd, 32'h11AA3344);
    run(2, 1'b1, 2'b01, 32'h20, 32'h00005566, lat, rd, e);
    run(2, 1'b0, 2'b00, 32'h20, 32'h0, lat, rd, e);
    check("half_lo_merge", rd, 32'h11AA5566);
    run(2, 1'b1, 2'b01, 32'h22, 32'hFFFF7788, lat, rd, e);
    run(2, 1'b1, 2'b10, 32'h23, 32'hFFFFFFCC, lat, rd, e);
    run(2, 1'b0, 2'b00, 32'h20, 32'h0, lat, rd, e);
    check("half_hi_byte3_merge", rd, 32'hCC885566);

    // Range boundary
    run(2, 1'b1, 2'b00, 32'h0, 32'h01020304, lat, rd, e);
    run(2, 1'b1, 2'b00, 32'h3FC, 32'hA5A5A5A5, lat, rd, e);
    run(2, 1'b0, 2'b00, 32'h3FC, 32'h0, lat, rd, e);
    check("last_word_data", rd, 32'hA5A5A5A5);
    check("last_word_err", e, 0);

    // Rejected accesses
    run(2, 1'b1, 2'b00, 32'h12, 32'hFFFFFFFF, lat, rd, e);
    check("mis_word_err", e, 1);
    check("mis_word_rdata", rd, 0);
    run(2, 1'b1, 2'b01, 32'h11, 32'hFFFFFFFF, lat, rd, e);
    check("mis_half_err", e, 1);
    check("mis_half_rdata", rd, 0);
    run(2, 1'b1, 2'b11, 32'h10, 32'hFFFFFFFF, lat, rd, e);
    check("ill_size_err", e, 1);
    check("ill_size_lat", lat, 2);
    run(2, 1'b1, 2'b00, 32'h400, 32'hFFFFFFFF, lat, rd, e);
    check("oor_err", e, 1);
    check("oor_rdata", rd, 0);
    check("err_clears", err_a, 0);
    run(2, 1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
    check("rd10_after_err", rd, 32'hDEADBEEF);
    run(2, 1'b0, 2'b00, 32'h0, 32'h0, lat, rd, e);
    check("rd0_after_oor", rd, 32'h01020304);

    // Single-cycle latency
    run(1, 1'b1, 2'b00, 32'h8, 32'h55AA55AA, lat, rd, e);
    check("lat1_wr_lat", lat, 1);
    run(1, 1'b0, 2'b00, 32'h8, 32'h0, lat, rd, e);
    check("lat1_rd_lat", lat, 1);
    check("lat1_rd_data", rd, 32'h55AA55AA);

    // Fifteen-cycle latency with the bus changing during the wait
    run(15, 1'b1, 2'b00, 32'h40, 32'h12345678, lat, rd, e);
    check("lat15_wr_lat", lat, 15);
    we = 1'b0; size = 2'b00; addr = 32'h40; wdata = 32'h0; req_c = 1'b1;
    check("lat15_busy_before", busy_c, 0);
    @(posedge clk); #1;
    n = 0;
    rd = '0;
    e = 1'b0;
    while (busy_c && n < 40) begin
      n++;
      if (ack_c) begin
        rd = rdata_c;
        e = 1'b1;
        req_c = 1'b0;
      end
      addr = addr ^ 32'h00000050;
      wdata = $urandom;
      @(posedge clk); #1;
    end
    check("lat15_busy_cycles", n, 15);
    check("lat15_ack_seen", e, 1);
    check("lat15_rdata", rd, 32'h12345678);

    // Reset while a write waits
    run(2, 1'b1, 2'b00, 32'h30, 32'h0, lat, rd, e);
    run(2, 1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
    check("rdata_held", rdata_a, 32'hDEADBEEF);
    we = 1'b1; size = 2'b00; addr = 32'h30; wdata = 32'hCAFEF00D; req_a = 1'b1;
    @(posedge clk); #1;
    check("midwr_busy", busy_a, 1);
    reset = 1'b1;
    req_a = 1'b0;
    #1;
    check("rst_ack", ack_a, 0);
    check("rst_err", err_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rdata", rdata_a, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run(2, 1'b0, 2'b00, 32'h30, 32'h0, lat, rd, e);
    check("rd30_after_rst", rd, 32'h0);

    // Request held high across ACK
    we = 1'b0; size = 2'b00; addr = 32'h10; req_a = 1'b1;
    acks = 0;
    first_ack = 0;
    last_ack = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (ack_a) begin
        acks++;
        if (first_ack == 0) first_ack = i;
        last_ack = i;
      end
    end
    req_a = 1'b0;
    check("held_ack_count", acks, 3);
    check("held_first_ack", first_ack, 2);
    check("held_last_ack", last_ack, 8);
    check("held_rdata", rdata_a, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
